halt_monitor_mc: RTL
====================

Name: halt_monitor_mc

Overview:
- Parametrised, multi-channel successor to the single-core halt probe.
- Watches halt/error/output-enable strobes of CH processor cores and classifies each core as RUN, HALTED, ERROR or TIMEOUT.
- Time-stamps each core's terminal event, counts its output writes, and raises aggregate done/pass flags.
- Sits in the FVE DUT wrapper between the platform's ports and the SV environment; it is also synthesisable for FPGA self-test.

Parameters:
- CH, 4, number of monitored cores (1..16)
- CNT_W, 32, width of the global cycle counter and time stamps
- OUT_W, 16, width of the per-channel output-write counters
- TO_W, 24, width of the watchdog limit

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-low
- clear_i  in  1  restart monitoring: all channels to RUN, all counters cleared
- cfg_timeout_i  in  TO_W  watchdog limit in cycles; 0 disables the watchdog
- halt_i  in  CH  per-core port_halt
- error_i  in  CH  per-core port_error
- out_en_i  in  CH  per-core port_out_en
- sel_i  in  max(1,$clog2(CH))  channel select for readback
- state_o  out  2*CH  per-channel state; channel k at [2k+1:2k]; 00 RUN, 01 HALTED, 10 ERROR, 11 TIMEOUT
- done_o  out  1  every channel is in a terminal state
- pass_o  out  1  done_o and every channel is HALTED
- event_o  out  1  one-cycle pulse when at least one channel leaves RUN
- cycle_o  out  CNT_W  global cycle counter
- stamp_o  out  CNT_W  terminal-event stamp of channel sel_i (0 while RUN)
- out_cnt_o  out  OUT_W  output-write count of channel sel_i

Behaviour:
- Reset (RST=0 at a CLK edge):
  - All states RUN; all counters and stamps 0; done_o, pass_o, event_o all 0.
  - Inputs are ignored during reset.
- cycle_o:
  - 0 in the first cycle after reset or clear; +1 every cycle after that.
  - Saturates at all-ones and never wraps.
- Per-channel FSM, evaluated every cycle. Priority within a cycle is error > halt > timeout.
  - RUN with error_i[k]=1 -> ERROR.
  - RUN with halt_i[k]=1 and no error -> HALTED.
  - RUN with cfg_timeout_i!=0 and cycle_o >= cfg_timeout_i (zero-extended) -> TIMEOUT.
  - HALTED, ERROR and TIMEOUT are sticky until clear_i or reset. Later halt/error strobes are ignored.
- Latency:
  - State, stamp, done_o, pass_o and event_o are all registered; they update on the edge after the input is sampled.
  - The stamp holds the cycle_o value of the sampling cycle.
- Output counter:
  - out_cnt[k] increments when out_en_i[k]=1 and state[k]=RUN. This includes the cycle in which halt or error is sampled.
  - Saturates at all-ones.
- event_o:
  - High for exactly one cycle per edge on which at least one channel leaves RUN.
  - Simultaneous transitions on several channels produce a single pulse.
- clear_i:
  - Same effect as reset, except it never touches the IRQ mask register of the optional feature.
  - clear_i wins over any halt/error/out_en strobe in the same cycle; those strobes are discarded.
- Readback:
  - sel_i is combinational to stamp_o/out_cnt_o.
  - sel_i >= CH returns 0 on both outputs.
- cfg_timeout_i may change at any time; the new value takes effect immediately.

Optional Feature:
- Macro HALT_MON_IRQ_EN.
- When defined, adds:
  - irq_mask_i (in, CH), loaded into a mask register each cycle that irq_load_i (in, 1) is high; cleared only by reset.
  - irq_o (out, 1): level, set on the edge a channel with mask bit 1 leaves RUN; stays high until irq_ack_i (in, 1).
  - If a new masked transition coincides with irq_ack_i, irq_o stays high.
- When undefined, none of these ports or registers exist and behaviour is otherwise identical.

Test Plan:
1. Reset, CH=4, cfg_timeout_i=0, halt_i[2] pulsed at cycle_o=10 -> state_o=0x0010, stamp(sel=2)=10, event_o one pulse, done_o=0.
2. Cycle 5: error_i[1] and halt_i[1] together; cycle 6: halt_i[1] again -> channel 1 ERROR, stamp 5, no second event_o.
3. cfg_timeout_i=100, no strobes -> all channels TIMEOUT with stamp 100, done_o=1, pass_o=0, a single event_o.
4. out_en_i[0] held 3 cycles, halt_i[0] on the 3rd cycle, out_en_i[0] held 2 more -> out_cnt(sel=0)=3.
5. All four halt at cycles 7,8,9,9 -> done_o=1 and pass_o=1 from cycle 10; then clear_i together with error_i[0] -> all RUN, cycle_o=0, ERROR not recorded.
6. HALT_MON_IRQ_EN defined, mask=0b0100, channel 0 halts, then channel 2 halts -> irq_o stays 0 for channel 0 and goes 1 after channel 2; ack drops it the next cycle; RST=0 mid-run clears mask and irq_o.

Source files
------------

// File: rtl/halt_monitor_mc.sv
// halt_monitor_mc: classifies CH cores as RUN/HALTED/ERROR/TIMEOUT, stamps terminal events and counts output writes.
// Define HALT_MON_IRQ_EN to build the masked level interrupt (irq_mask_i/irq_load_i/irq_ack_i/irq_o).
module halt_monitor_mc #(
   parameter int CH    = 4,
   parameter int CNT_W = 32,
   parameter int OUT_W = 16,
   parameter int TO_W  = 24,
   localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              clear_i,
   input  logic [TO_W-1:0]   cfg_timeout_i,
   input  logic [CH-1:0]     halt_i,
   input  logic [CH-1:0]     error_i,
   input  logic [CH-1:0]     out_en_i,
   input  logic [SEL_W-1:0]  sel_i,
`ifdef HALT_MON_IRQ_EN
   input  logic [CH-1:0]     irq_mask_i,
   input  logic              irq_load_i,
   input  logic              irq_ack_i,
   output logic              irq_o,
`endif
   output logic [2*CH-1:0]   state_o,
   output logic              done_o,
   output logic              pass_o,
   output logic              event_o,
   output logic [CNT_W-1:0]  cycle_o,
   output logic [CNT_W-1:0]  stamp_o,
   output logic [OUT_W-1:0]  out_cnt_o
);

   localparam int CMP_W = (CNT_W > TO_W) ? CNT_W : TO_W;

   typedef enum logic [1:0] {
      ST_RUN     = 2'b00,
      ST_HALTED  = 2'b01,
      ST_ERROR   = 2'b10,
      ST_TIMEOUT = 2'b11
   } ch_state_t;

   ch_state_t         state_q [CH];
   ch_state_t         state_d [CH];
   logic [CNT_W-1:0]  stamp_q [CH];
   logic [OUT_W-1:0]  out_cnt_q [CH];
   logic [CNT_W-1:0]  cycle_q;
   logic [CH-1:0]     leave;
   logic              all_term;
   logic              all_halt;
   logic              to_hit;
   logic              done_q;
   logic              pass_q;
   logic              event_q;

   // Watchdog compares the live limit against the current cycle count, zero-extended to a common width.
   assign to_hit = (cfg_timeout_i != '0) && (CMP_W'(cycle_q) >= CMP_W'(cfg_timeout_i));

   always_comb begin
      leave    = '0;
      all_term = 1'b1;
      all_halt = 1'b1;
      for (int k = 0; k < CH; k++) begin
         state_d[k] = state_q[k];
         if (state_q[k] == ST_RUN) begin
            if (error_i[k])
               state_d[k] = ST_ERROR;
            else if (halt_i[k])
               state_d[k] = ST_HALTED;
            else if (to_hit)
               state_d[k] = ST_TIMEOUT;
         end
         leave[k] = (state_q[k] == ST_RUN) && (state_d[k] != ST_RUN);
         if (state_d[k] == ST_RUN)
            all_term = 1'b0;
         if (state_d[k] != ST_HALTED)
            all_halt = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST || clear_i) begin
         cycle_q <= '0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         event_q <= 1'b0;
         for (int k = 0; k < CH; k++) begin
            state_q[k]   <= ST_RUN;
            stamp_q[k]   <= '0;
            out_cnt_q[k] <= '0;
         end
      end else begin
         if (cycle_q != '1)
            cycle_q <= cycle_q + CNT_W'(1);
         // Writes in the sampling cycle of halt/error still count: the gate is the pre-edge state.
         for (int k = 0; k < CH; k++) begin
            state_q[k] <= state_d[k];
            if (leave[k])
               stamp_q[k] <= cycle_q;
            if (out_en_i[k] && (state_q[k] == ST_RUN) && (out_cnt_q[k] != '1))
               out_cnt_q[k] <= out_cnt_q[k] + OUT_W'(1);
         end
         done_q  <= all_term;
         pass_q  <= all_term && all_halt;
         event_q <= |leave;
      end
   end

`ifdef HALT_MON_IRQ_EN
   logic [CH-1:0] mask_q;
   logic          irq_q;

   // The mask survives clear_i; only the hardware reset empties it.
   always_ff @(posedge CLK) begin
      if (!RST)
         mask_q <= '0;
      else if (irq_load_i)
         mask_q <= irq_mask_i;
   end

   always_ff @(posedge CLK) begin
      if (!RST || clear_i)
         irq_q <= 1'b0;
      else if (|(leave & mask_q))
         irq_q <= 1'b1;
      else if (irq_ack_i)
         irq_q <= 1'b0;
   end

   assign irq_o = irq_q;
`endif

   always_comb begin
      state_o = '0;
      for (int k = 0; k < CH; k++)
         state_o[2*k +: 2] = state_q[k];
   end

   always_comb begin
      stamp_o   = '0;
      out_cnt_o = '0;
      if (int'(sel_i) < CH) begin
         stamp_o   = stamp_q[sel_i];
         out_cnt_o = out_cnt_q[sel_i];
      end
   end

   assign done_o  = done_q;
   assign pass_o  = pass_q;
   assign event_o = event_q;
   assign cycle_o = cycle_q;

endmodule
